// File: rtl/multibyte_add_seq.sv
// Sequential multi-byte adder: one 8-bit carry-select add per clock, LSB byte first.
// Optional MULTIBYTE_ADD_SEQ_OVF_EN adds a registered two's-complement overflow output.

module carry_select (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);
   logic [4:0] lo;
   logic [4:0] hi0;
   logic [4:0] hi1;

   // Upper nibble is precomputed for both possible carries and selected by the low carry.
   assign lo     = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0000, cin_i};
   assign hi0    = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
   assign hi1    = hi0 + 5'd1;
   assign sum_o  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
   assign cout_o = lo[4] ? hi1[4] : hi0[4];
endmodule

module multibyte_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   sum,
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
   output logic                  ovf,
`endif
   output logic                  cout
);
   localparam int W  = 8 * NBYTES;
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic            carry_q, carry_d, cout_q, cout_d, rdy_q, rdy_d;
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
   logic            ovf_q, ovf_d;
`endif
   logic [7:0]      aByte, bByte, sByte;
   logic            cByte;

   always_comb begin
      aByte = '0;
      bByte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (k_q == KW'(i)) begin
            aByte = a_q[8*i +: 8];
            bByte = b_q[8*i +: 8];
         end
      end
   end

   carry_select u_byte (
      .a_i   (aByte),
      .b_i   (bByte),
      .cin_i (carry_q),
      .sum_o (sByte),
      .cout_o(cByte)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && rdy_q) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NBYTES; i++) begin
               if (k_q == KW'(i)) sum_d[8*i +: 8] = sByte;
            end
            carry_d = cByte;
            if (k_q == KLAST) begin
               state_d = DONE;
               cout_d  = cByte;
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (sByte[7] != a_q[W-1]);
`endif
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Ready is registered so it stays low during reset and rises on the first edge after.
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         rdy_q   <= rdy_d;
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq: directed and random checks on NBYTES=4, 1 and 16 instances.
// Build with MULTIBYTE_ADD_SEQ_OVF_EN defined to also exercise the overflow output.

module tb_multibyte_add_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   logic        v4, or4, cin4, rdy4, ov4, co4;
   logic [31:0] a4, b4, s4;

   logic         selBig, bV, bOR, bCin;
   logic [127:0] bA, bB;
   logic         rdy1, ov1, co1, rdy16, ov16, co16;
   logic [7:0]   s1;
   logic [127:0] s16;
   logic         bRdy, bOv, bCo;
   logic [127:0] bSum;
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
   logic         ovf4, ovf1, ovf16;
`endif

   assign bRdy = selBig ? rdy16 : rdy1;
   assign bOv  = selBig ? ov16  : ov1;
   assign bCo  = selBig ? co16  : co1;
   assign bSum = selBig ? s16   : {120'b0, s1};

   multibyte_add_seq #(.NBYTES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(or4),
      .sum(s4),
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
      .ovf(ovf4),
`endif
      .cout(co4)
   );

   multibyte_add_seq #(.NBYTES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(bV & ~selBig), .in_ready(rdy1),
      .a(bA[7:0]), .b(bB[7:0]), .cin(bCin), .out_valid(ov1), .out_ready(bOR),
      .sum(s1),
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
      .ovf(ovf1),
`endif
      .cout(co1)
   );

   multibyte_add_seq #(.NBYTES(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(bV & selBig), .in_ready(rdy16),
      .a(bA), .b(bB), .cin(bCin), .out_valid(ov16), .out_ready(bOR),
      .sum(s16),
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
      .ovf(ovf16),
`endif
      .cout(co16)
   );

   // Offers one operand set to dut4 and returns at the first negedge with out_valid high.
   // lat counts negedges after the accept cycle; -1 means a bound expired.
   task automatic do_add4(input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
      int n;
      a4 = a; b4 = b; cin4 = c; v4 = 1'b1;
      n = 0;
      while (!rdy4 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!rdy4) begin
         v4 = 1'b0;
         lat = -1;
         return;
      end
      @(negedge clk);
      v4 = 1'b0;
      a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom_range(0, 1));
      lat = 1;
      while (!ov4 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!ov4) lat = -1;
   endtask

   task automatic release4();
      or4 = 1'b1;
      @(negedge clk);
      or4 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; v4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      selBig = 1'b0; bV = 1'b0; bOR = 1'b0; bA = '0; bB = '0; bCin = 1'b0;
      #2;
      checks++; if (rdy4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", rdy4); end
      checks++; if (ov4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", ov4); end
      checks++; if (s4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 00000000", s4); end
      checks++; if (co4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout: got %b expected 0", co4); end
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (rdy4 !== 1'b0) begin errors++; $display("[TB] FAIL release_before_edge_in_ready: got %b expected 0", rdy4); end
      @(negedge clk);
      checks++; if ({rdy4, rdy1, rdy16} !== 3'b111) begin errors++; $display("[TB] FAIL first_edge_in_ready: got %b expected 111", {rdy4, rdy1, rdy16}); end
   endtask

   task automatic test_basic();
      int lat;
      do_add4(32'h000000FF, 32'h00000001, 1'b0, lat);
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL carry8_latency: got %0d expected 5", lat); end
      checks++; if (s4 !== 32'h00000100) begin errors++; $display("[TB] FAIL carry8_sum: got %h expected 00000100", s4); end
      checks++; if (co4 !== 1'b0) begin errors++; $display("[TB] FAIL carry8_cout: got %b expected 0", co4); end
      release4();
      do_add4(32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL ripple_latency: got %0d expected 5", lat); end
      checks++; if (s4 !== 32'h00000000) begin errors++; $display("[TB] FAIL ripple_sum: got %h expected 00000000", s4); end
      checks++; if (co4 !== 1'b1) begin errors++; $display("[TB] FAIL ripple_cout: got %b expected 1", co4); end
      release4();
   endtask

   task automatic test_random4();
      int lat;
      logic [31:0] a, b;
      logic c;
      logic [32:0] full;
      for (int i = 0; i < 6; i++) begin
         a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
         full = {1'b0, a} + {1'b0, b} + 33'(c);
         do_add4(a, b, c, lat);
         checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL rand4_latency: got %0d expected 5", lat); end
         checks++; if ({co4, s4} !== full) begin errors++; $display("[TB] FAIL rand4_result: got %b_%h expected %b_%h", co4, s4, full[32], full[31:0]); end
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
         checks++;
         if (ovf4 !== ((a[31] == b[31]) && (full[31] != a[31]))) begin
            errors++; $display("[TB] FAIL rand4_ovf: got %b expected %b", ovf4, (a[31] == b[31]) && (full[31] != a[31]));
         end
`endif
         release4();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [31:0] hs;
      logic hc;
      do_add4(32'hDEADBEEF, 32'h01234567, 1'b1, lat);
      hs = 32'hDEADBEEF + 32'h01234567 + 32'h1;
      hc = 1'b0;
      checks++; if ({co4, s4} !== {hc, hs}) begin errors++; $display("[TB] FAIL bp_result: got %b_%h expected %b_%h", co4, s4, hc, hs); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++; if (ov4 !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid: got %b expected 1 at hold %0d", ov4, i); end
         checks++; if ({co4, s4} !== {hc, hs}) begin errors++; $display("[TB] FAIL bp_hold: got %b_%h expected %b_%h at hold %0d", co4, s4, hc, hs, i); end
         checks++; if (rdy4 !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected 0 at hold %0d", rdy4, i); end
      end
      release4();
      checks++; if ({ov4, rdy4} !== 2'b01) begin errors++; $display("[TB] FAIL bp_complete: got out_valid,in_ready=%b expected 01", {ov4, rdy4}); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      bit seen;
      a4 = 32'hCAFEF00D; b4 = 32'h0BADBEEF; cin4 = 1'b0; v4 = 1'b1;
      checks++; if (rdy4 !== 1'b1) begin errors++; $display("[TB] FAIL midrun_pre_ready: got %b expected 1", rdy4); end
      @(negedge clk);
      v4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({rdy4, ov4, co4} !== 3'b000) begin errors++; $display("[TB] FAIL midrun_reset_flags: got %b expected 000", {rdy4, ov4, co4}); end
      checks++; if (s4 !== 32'h0) begin errors++; $display("[TB] FAIL midrun_reset_sum: got %h expected 00000000", s4); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (rdy4 !== 1'b1) begin errors++; $display("[TB] FAIL midrun_release_ready: got %b expected 1", rdy4); end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (ov4) seen = 1'b1;
         @(negedge clk);
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midrun_no_result: got out_valid seen=%b expected 0", seen); end
      do_add4(32'h12345678, 32'h11111111, 1'b0, lat);
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 5", lat); end
      checks++; if ({co4, s4} !== 33'h023456789) begin errors++; $display("[TB] FAIL post_reset_sum: got %b_%h expected 0_23456789", co4, s4); end
      release4();
   endtask

`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
   task automatic test_ovf();
      int lat;
      do_add4(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
      checks++; if (ovf4 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pos: got %b expected 1", ovf4); end
      checks++; if (s4 !== 32'h80000000) begin errors++; $display("[TB] FAIL ovf_pos_sum: got %h expected 80000000", s4); end
      release4();
      do_add4(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
      checks++; if (ovf4 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_neg: got %b expected 0", ovf4); end
      checks++; if (co4 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_neg_cout: got %b expected 1", co4); end
      release4();
   endtask
`endif

   typedef struct {
      logic [127:0] s;
      logic         c;
      int           cyc;
   } exp_t;

   // Streams random adds with in_valid and out_ready held high, tracking expected results in a queue.
   task automatic test_back_to_back(input bit big);
      int nb, cyc, lastAcc, done;
      logic [127:0] mask;
      logic [128:0] full;
      exp_t q[$];
      exp_t e;
      nb = big ? 16 : 1;
      mask = big ? {128{1'b1}} : 128'hFF;
      selBig = big; bOR = 1'b1; bV = 1'b1;
      cyc = 0; lastAcc = -1; done = 0;
      while (done < 8 && cyc < 2000) begin
         if (bOv) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("[TB] FAIL b2b_n%0d_unexpected: got out_valid with no pending add", nb);
            end else begin
               e = q.pop_front();
               if ({bCo, bSum} !== {e.c, e.s} || (cyc - e.cyc) != nb + 1) begin
                  errors++;
                  $display("[TB] FAIL b2b_n%0d_result: got %b_%h after %0d expected %b_%h after %0d",
                           nb, bCo, bSum, cyc - e.cyc, e.c, e.s, nb + 1);
               end
            end
            done++;
         end
         bA = {$urandom, $urandom, $urandom, $urandom};
         bB = ($urandom_range(0, 3) == 0) ? ~bA : {$urandom, $urandom, $urandom, $urandom};
         bCin = 1'($urandom_range(0, 1));
         if (bRdy) begin
            if (lastAcc >= 0) begin
               checks++;
               if (cyc - lastAcc != nb + 2) begin
                  errors++; $display("[TB] FAIL b2b_n%0d_interval: got %0d expected %0d", nb, cyc - lastAcc, nb + 2);
               end
            end
            lastAcc = cyc;
            full = {1'b0, bA & mask} + {1'b0, bB & mask} + 129'(bCin);
            e.s = full[127:0] & mask;
            e.c = full[8*nb];
            e.cyc = cyc;
            q.push_back(e);
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done < 8) begin errors++; $display("[TB] FAIL b2b_n%0d_timeout: got %0d results expected 8", nb, done); end
      bV = 1'b0;
      repeat (nb + 4) @(negedge clk);
      bOR = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random4();
      test_backpressure();
      test_reset_mid_run();
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
      test_ovf();
`endif
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning an operand set is offered.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept an operand set.
REQ-006 SHALL have port a, input, 8*NBYTES, operand A.
REQ-007 SHALL have port b, input, 8*NBYTES, operand B.
REQ-008 SHALL have port cin, input, 1, carry-in of the whole addition.
REQ-009 SHALL have port out_valid, output, 1, meaning the result is held on sum/cout.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port sum, output, 8*NBYTES, result bits.
REQ-012 SHALL have port cout, output, 1, carry-out of the MSB.

Function
REQ-013 SHALL perform each byte addition with one instance of the team's 8-bit carry_select adder, one byte per clock, LSB byte first.
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL assert in_ready only in IDLE, and out_valid only in DONE.
REQ-016 SHALL, on a cycle with in_valid&in_ready, latch a, b and cin, clear byte index k to 0, and enter RUN.
REQ-017 SHALL, in each RUN cycle, add byte k of A and B plus the carry register, write the byte into sum[8k+7:8k], load the carry register with the byte carry-out, and increment k.
REQ-018 SHALL, on the RUN cycle with k==NBYTES-1, enter DONE and load cout from the final byte carry.
REQ-019 SHALL assert out_valid exactly NBYTES+1 cycles after the accept edge (NBYTES=1: 2 cycles).
REQ-020 SHALL hold sum, cout and out_valid stable in DONE until out_valid&out_ready, then return to IDLE on the next cycle.
REQ-021 SHALL NOT accept a new operand in the DONE-exit cycle; the minimum issue interval is NBYTES+2 cycles.
REQ-022 SHALL ignore changes on a, b and cin outside the accept cycle.
REQ-023 SHALL produce sum = (A+B+cin) mod 2^(8*NBYTES), with cout = bit 8*NBYTES of the full sum.
REQ-024 SHALL leave the bytes of sum not yet computed at their previous values during RUN; sum is valid only while out_valid is high.

Reset
REQ-025 SHALL, while rst_n is low, immediately force state IDLE, k=0, the carry register to 0, sum to 0, cout to 0, out_valid to 0 and in_ready to 0.
REQ-026 SHALL drive in_ready to 1 on the first clock edge after rst_n deasserts.
REQ-027 SHALL, when reset occurs mid-RUN or in DONE, discard the operation and never present a partial result.

Configuration
REQ-028 SHALL, when macro MULTIBYTE_ADD_SEQ_OVF_EN is defined, add output port ovf, 1 bit, reset 0, equal to the two's-complement overflow: (A msb == B msb) and (sum msb != A msb), registered with cout and valid with out_valid.
REQ-029 SHALL, without MULTIBYTE_ADD_SEQ_OVF_EN, have no ovf port and no overflow logic.

Verification
REQ-030 SHALL test NBYTES=4 with a=0x000000FF, b=0x00000001, cin=0 -> out_valid at accept+5, sum=0x00000100, cout=0.
REQ-031 SHALL test a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1; the carry ripples through all four bytes.
REQ-032 SHALL test backpressure with out_ready low for 10 cycles after out_valid -> sum, cout and out_valid stay constant and in_ready=0 throughout; completion follows the first out_ready.
REQ-033 SHALL test rst_n pulsed low at RUN byte 2 -> out_valid never rises for that operation, in_ready=1 one edge after release, and the next add 0x12345678+0x11111111 gives 0x23456789.
REQ-034 SHALL test, with MULTIBYTE_ADD_SEQ_OVF_EN, a=0x7FFFFFFF, b=0x00000001 -> ovf=1, sum=0x80000000; and a=0xFFFFFFFF, b=0x00000001 -> ovf=0, cout=1.
REQ-035 SHALL test random back-to-back adds for NBYTES=1 and NBYTES=16 against a reference model, with in_valid held high -> every result matches and the issue interval equals NBYTES+2.
